clock_step_controller: RTL

CLOCK_STEP_CONTROLLER -- requirements
Module: clock_step_controller

---
 rtl/clock_step_controller.sv | 137 +++++++++++++
 1 files changed

// File: rtl/clock_step_controller.sv
// CPU clock-step controller: free-run divider ticks, single-step pulses and halt/resume.
// Optional button debounce enabled by defining CLOCK_STEP_DEBOUNCE_EN.
//
// state      | meaning
// RUN        | divider running, cpu_en on each divider wrap of the selected tap
// STEP_WAIT  | divider cleared, waiting for a button press
// STEP_PULSE | single cpu_en cycle, then back to STEP_WAIT
// HALTED     | frozen by halt, resumes on a press once halt is low
module clock_step_controller #(
  parameter int DIV_SLOW = 23,
  parameter int DIV_FAST = 13,
  parameter int DEB_BITS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        modo_passo,
  input  logic        veloc,
  input  logic        botao,
  input  logic        halt,
  output logic        cpu_en,
  output logic [1:0]  estado,
  output logic [15:0] passos
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    STEP_WAIT  = 2'b01,
    STEP_PULSE = 2'b10,
    HALTED     = 2'b11
  } state_t;

  // Masks cover the low (tap+1) bits; a tap of 31 wraps the shift to an all-ones mask.
  localparam logic [31:0] MASK_FAST = (32'd1 << (DIV_FAST + 1)) - 32'd1;
  localparam logic [31:0] MASK_SLOW = (32'd1 << (DIV_SLOW + 1)) - 32'd1;

  state_t      r_state;
  logic        r_cpu_en;
  logic [31:0] r_div;
  logic [15:0] r_passos;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_btn_prev;
  logic        w_btn;
  logic        w_press;
  logic [31:0] w_mask;
  logic        w_tap_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= botao;
      r_sync2 <= r_sync1;
    end
  end

`ifdef CLOCK_STEP_DEBOUNCE_EN
  logic                r_deb_btn;
  logic [DEB_BITS-1:0] r_deb_cnt;

  // Any return to the current level restarts the window.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_deb_btn <= 1'b0;
      r_deb_cnt <= '0;
    end else if (r_sync2 == r_deb_btn) begin
      r_deb_cnt <= '0;
    end else if (&r_deb_cnt) begin
      r_deb_btn <= r_sync2;
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  assign w_btn = r_deb_btn;
`else
  assign w_btn = r_sync2;
`endif

  always_ff @(posedge clock) begin
    if (reset) r_btn_prev <= 1'b0;
    else       r_btn_prev <= w_btn;
  end

  assign w_press   = w_btn & ~r_btn_prev;
  assign w_mask    = veloc ? MASK_FAST : MASK_SLOW;
  assign w_tap_hit = ((r_div & w_mask) == w_mask);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= STEP_WAIT;
      r_cpu_en <= 1'b0;
      r_div    <= '0;
      r_passos <= '0;
    end else begin
      r_passos <= r_passos + {15'd0, r_cpu_en};
      r_cpu_en <= 1'b0;
      r_div    <= '0;
      case (r_state)
        RUN: begin
          if (halt) begin
            r_state <= HALTED;
          end else if (modo_passo) begin
            r_state <= STEP_WAIT;
          end else begin
            r_div    <= r_div + 32'd1;
            r_cpu_en <= w_tap_hit;
          end
        end
        STEP_WAIT: begin
          if (halt) begin
            r_state <= HALTED;
          end else if (!modo_passo) begin
            r_state <= RUN;
          end else if (w_press) begin
            r_state  <= STEP_PULSE;
            r_cpu_en <= 1'b1;
          end
        end
        STEP_PULSE: begin
          r_state <= halt ? HALTED : STEP_WAIT;
        end
        HALTED: begin
          if (w_press && !halt) r_state <= modo_passo ? STEP_WAIT : RUN;
        end
        default: r_state <= STEP_WAIT;
      endcase
    end
  end

  assign cpu_en = r_cpu_en;
  assign estado = r_state;
  assign passos = r_passos;

endmodule
